// File: rtl/alu_mc_pkg.sv
// Shared constants for alu_mc: op-codes, FSM state encoding and WIDTH limits.
package alu_mc_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// o_done/o_product flag the final iteration and carry the value it produces.
module alu_mc_mul
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_upper;

  // Upper half accumulates the multiplicand when the multiplier LSB is set,
  // then the whole register shifts right, carry included.
  assign w_upper   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_prod[0]}} & r_a};
  assign o_product = {w_upper, r_prod[WIDTH-1:1]};
  assign o_done    = r_busy && (r_cnt == LAST);

  // NOTE: state uses non-blocking assignments and an async reset so every
  // register updates from pre-edge values and clears the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_a    <= '0;
      r_prod <= '0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_prod <= {{WIDTH{1'b0}}, i_b};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_prod <= o_product;
      if (o_done) r_busy <= 1'b0;
      else        r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake; single-cycle ops, optional iterative MUL.
// Define ALU_MC_MUL_EN to build the multiplier and BUSY state; otherwise op 6 is illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             err
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("alu_mc: WIDTH outside supported range");
  end

  state_t           r_state, w_next, w_accept_state;
  logic             w_xfer, w_direct;
  logic [WIDTH-1:0] r_res, r_res_hi;
  logic             r_cout, r_ovf, r_zero, r_err;

  logic             w_sub, w_add_ovf, w_lt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cout, w_ovf, w_err;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign w_xfer    = in_valid && in_ready;

`ifdef ALU_MC_MUL_EN
  logic               w_is_mul, w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_is_mul       = (op == OP_MUL);
  assign w_direct       = w_xfer && !w_is_mul;
  assign w_accept_state = w_is_mul ? S_BUSY : S_DONE;

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_xfer && w_is_mul),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`else
  assign w_direct       = w_xfer;
  assign w_accept_state = S_DONE;
`endif

  // SUB and SLT share the adder in subtract mode; SLT corrects the sign with overflow.
  assign w_sub     = (op == OP_SUB) || (op == OP_SLT);
  assign w_sum     = {1'b0, a} + {1'b0, b ^ {WIDTH{w_sub}}} + {{WIDTH{1'b0}}, w_sub};
  assign w_add_ovf = (a[WIDTH-1] == (b[WIDTH-1] ^ w_sub)) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_lt      = w_sum[WIDTH-1] ^ w_add_ovf;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    w_err  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = w_add_ovf;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_MC_MUL_EN
      OP_MUL: w_res = '0;
`else
      OP_MUL: w_err = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_xfer) w_next = w_accept_state;
`ifdef ALU_MC_MUL_EN
      S_BUSY: if (w_mul_done) w_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_next = w_xfer ? w_accept_state : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_res    <= '0;
      r_res_hi <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_direct) begin
        r_res    <= w_res;
        r_res_hi <= '0;
        r_cout   <= w_cout;
        r_ovf    <= w_ovf;
        r_zero   <= (w_res == '0);
        r_err    <= w_err;
      end
`ifdef ALU_MC_MUL_EN
      else if (w_mul_done) begin
        r_res    <= w_mul_prod[WIDTH-1:0];
        r_res_hi <= w_mul_prod[2*WIDTH-1:WIDTH];
        r_cout   <= 1'b0;
        r_ovf    <= 1'b0;
        r_zero   <= (w_mul_prod == '0);
        r_err    <= 1'b0;
      end
`endif
    end
  end

  assign res    = r_res;
  assign res_hi = r_res_hi;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed corner cases plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_alu_mc;

  localparam int W = 8;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         err;
  } exp_t;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, res, res_hi;
  logic [2:0]   op;
  logic         cout, ovf, zero, err;

  int n_pass  = 0;
  int n_total = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .cout(cout), .ovf(ovf), .zero(zero), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the result an op must produce, from plain integer arithmetic.
  function automatic exp_t ref_calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    longint ux, uy, sx, sy, s;
    r  = '0;
    ux = x;
    uy = y;
    sx = x[W-1] ? ux - (longint'(1) << W) : ux;
    sy = y[W-1] ? uy - (longint'(1) << W) : uy;
    case (o)
      3'd0: begin
        s = ux + uy;  r.res = W'(s);  r.cout = (s >= (longint'(1) << W));
        s = sx + sy;  r.ovf = (s > SMAX) || (s < SMIN);
      end
      3'd1: begin
        s = ux - uy;  r.res = W'(s);  r.cout = (ux >= uy);
        s = sx - sy;  r.ovf = (s > SMAX) || (s < SMIN);
      end
      3'd2: r.res = x & y;
      3'd3: r.res = x | y;
      3'd4: r.res = x ^ y;
      3'd5: r.res = (sx < sy) ? W'(1) : W'(0);
      3'd6: begin
        if (MUL_EN) begin
          s = ux * uy;  r.res = W'(s);  r.res_hi = W'(s >> W);
        end else r.err = 1'b1;
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.res == '0) && (r.res_hi == '0);
    return r;
  endfunction

  // Transaction model: one result slot, plus a countdown while a multiply is in flight.
  exp_t m_cur, m_pend, m_e;
  bit   m_valid, m_rdy, m_xfer;
  int   m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_left  = 0;
    end else begin
      m_rdy  = (m_left == 0) && (!m_valid || out_ready);
      m_xfer = in_valid && m_rdy;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_cur   = m_pend;
        end
      end else if (m_valid && out_ready) m_valid = 1'b0;
      if (m_xfer) begin
        m_e = ref_calc(op, a, b);
        if (MUL_EN && op == 3'd6) begin
          m_pend  = m_e;
          m_left  = W;
          m_valid = 1'b0;
        end else begin
          m_cur   = m_e;
          m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_in_ready", in_ready, (m_left == 0) && (!m_valid || out_ready));
      check("cmp_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("cmp_res", res, m_cur.res);
        check("cmp_res_hi", res_hi, m_cur.res_hi);
        check("cmp_cout", cout, m_cur.cout);
        check("cmp_ovf", ovf, m_cur.ovf);
        check("cmp_zero", zero, m_cur.zero);
        check("cmp_err", err, m_cur.err);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    align();
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] r, input logic [W-1:0] rh,
                              input logic c, input logic v, input logic z, input logic e);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_res"}, res, r);
    check({tag, "_res_hi"}, res_hi, rh);
    check({tag, "_cout"}, cout, c);
    check({tag, "_ovf"}, ovf, v);
    check({tag, "_zero"}, zero, z);
    check({tag, "_err"}, err, e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_res"}, res, '0);
    check({tag, "_res_hi"}, res_hi, '0);
    check({tag, "_cout"}, cout, 1'b0);
    check({tag, "_ovf"}, ovf, 1'b0);
    check({tag, "_zero"}, zero, 1'b1);
    check({tag, "_err"}, err, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [4];
    corners[0] = 8'h00;  corners[1] = 8'hFF;  corners[2] = 8'h80;  corners[3] = 8'h7F;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    exp_t e;
    rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
    a = '0;  b = '0;  op = '0;

    e = ref_calc(3'd0, 8'hFF, 8'h01);
    check("model_add", {e.res, e.cout, e.ovf, e.zero}, {8'h00, 1'b1, 1'b0, 1'b1});
    e = ref_calc(3'd1, 8'h80, 8'h01);
    check("model_sub", {e.res, e.cout, e.ovf}, {8'h7F, 1'b1, 1'b1});
    e = ref_calc(3'd5, 8'h80, 8'h7F);
    check("model_slt", e.res, 8'h01);
    e = ref_calc(3'd1, 8'h01, 8'h02);
    check("model_borrow", {e.res, e.cout}, {8'hFF, 1'b0});

    #12;
    check_reset_vals("reset");
    align();
    rst_n = 1'b1;

    send(3'd0, 8'hFF, 8'h01);
    @(negedge clk);
    check_result("add_wrap", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    align();
    send(3'd1, 8'h80, 8'h01);
    @(negedge clk);
    check_result("sub_ovf", 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    align();
    send(3'd5, 8'h80, 8'h7F);
    @(negedge clk);
    check_result("slt_neg", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    align();
    send(3'd5, 8'h7F, 8'h80);
    @(negedge clk);
    check_result("slt_pos", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    align();
    send(3'd7, 8'h12, 8'h34);
    @(negedge clk);
    check_result("op7_illegal", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    align();

    send(3'd6, 8'hFF, 8'hFF);
    if (MUL_EN) begin
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        check("mul_busy_in_ready", in_ready, 1'b0);
        check("mul_busy_out_valid", out_valid, 1'b0);
      end
      @(negedge clk);
      check_result("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      @(negedge clk);
      check_result("op6_illegal", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    align();

    out_ready = 1'b0;
    send(3'd0, 8'h12, 8'h34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check_result("stall_hold", 8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      align();
    end
    out_ready = 1'b1;
    send(3'd2, 8'hF0, 8'h3C);
    @(negedge clk);
    check_result("b2b_and", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    align();

    if (MUL_EN) send(3'd6, 8'h0D, 8'h0B);
    else begin
      out_ready = 1'b0;
      send(3'd0, 8'h01, 8'h02);
    end
    repeat (3) align();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    align();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("postreset_in_ready", in_ready, 1'b1);
      check("postreset_out_valid", out_valid, 1'b0);
    end
    align();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      align();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2 * W + 4) align();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
